// File: rtl/sisc_pkg.sv
// Shared constants for the SISC execute slice: opcodes, ALU functions, FSM states, status bits.
// Optional macro SISC_IMM_SIGNEXT_EN: sign-extend the 16-bit immediate instead of zero-extending.
package sisc_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STAT_W  = 4;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned MM_W    = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned STATE_W = 3;

  localparam logic [OP_W-1:0] OP_NOP     = 4'h0;
  localparam logic [OP_W-1:0] OP_ALU_REG = 4'h1;
  localparam logic [OP_W-1:0] OP_ALU_IMM = 4'h2;
  localparam logic [OP_W-1:0] OP_LOD     = 4'h8;
  localparam logic [OP_W-1:0] OP_HLT     = 4'hF;

  localparam logic [MM_W-1:0] MM_ADD = 4'h0;
  localparam logic [MM_W-1:0] MM_SUB = 4'h1;
  localparam logic [MM_W-1:0] MM_NOT = 4'h2;
  localparam logic [MM_W-1:0] MM_OR  = 4'h3;
  localparam logic [MM_W-1:0] MM_AND = 4'h4;
  localparam logic [MM_W-1:0] MM_XOR = 4'h5;
  localparam logic [MM_W-1:0] MM_SHL = 4'h6;
  localparam logic [MM_W-1:0] MM_SHR = 4'h7;

  localparam logic [STATE_W-1:0] ST_RESET     = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH     = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE    = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXECUTE   = 3'd3;
  localparam logic [STATE_W-1:0] ST_MEM       = 3'd4;
  localparam logic [STATE_W-1:0] ST_WRITEBACK = 3'd5;
  localparam logic [STATE_W-1:0] ST_HALT      = 3'd6;

  localparam int unsigned STAT_Z = 0;
  localparam int unsigned STAT_N = 1;
  localparam int unsigned STAT_V = 2;
  localparam int unsigned STAT_C = 3;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [MM_W-1:0]  mm;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [IMM_W-1:0] imm;
  } instr_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op == OP_ALU_REG) || (op == OP_ALU_IMM);
  endfunction

  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm);
`ifdef SISC_IMM_SIGNEXT_EN
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
`else
    return {{(DATA_W-IMM_W){1'b0}}, imm};
`endif
  endfunction

endpackage

// File: rtl/sisc_exec_unit_if.sv
// Bus between the SISC execute slice and its register file / status register / load path.
interface sisc_exec_unit_if;
  import sisc_pkg::*;

  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] rsa;
  logic [DATA_W-1:0] rsb;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] alu_result;
  logic [STAT_W-1:0] stat;
  logic              stat_en;
  logic              rf_we;
  logic              wb_sel;
  logic [DATA_W-1:0] write_data;
  logic              halted;

  modport master (
    output ir, rsa, rsb, mem_data,
    input  alu_result, stat, stat_en, rf_we, wb_sel, write_data, halted
  );

  modport slave (
    input  ir, rsa, rsb, mem_data,
    output alu_result, stat, stat_en, rf_we, wb_sel, write_data, halted
  );
endinterface

// File: rtl/sisc_alu_core.sv
// Pure combinational 32-bit ALU; flags are {C,V,N,Z}, with C as borrow on subtract.
module sisc_alu_core
  import sisc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [MM_W-1:0]   mm,
  output logic [DATA_W-1:0] result,
  output logic [STAT_W-1:0] flags
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            carry;
  logic            ovf;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // mm 8..F passes A through with C=V=0
  always_comb begin
    result = a;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (mm)
      MM_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      MM_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
        ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      MM_NOT:  result = ~a;
      MM_OR:   result = a | b;
      MM_AND:  result = a & b;
      MM_XOR:  result = a ^ b;
      MM_SHL:  result = a << b[4:0];
      MM_SHR:  result = a >> b[4:0];
      default: result = a;
    endcase
    flags         = '0;
    flags[STAT_C] = carry;
    flags[STAT_V] = ovf;
    flags[STAT_N] = result[DATA_W-1];
    flags[STAT_Z] = (result == '0);
  end

endmodule

// File: rtl/sisc_exec_unit.sv
// SISC execute/control slice: multi-cycle control FSM, ALU instance and writeback mux.
// Immediate extension follows SISC_IMM_SIGNEXT_EN (sign-extend when defined, zero-extend otherwise).
module sisc_exec_unit
  import sisc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_f,
  sisc_exec_unit_if.slave bus
);

  instr_t            instr;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic [STAT_W-1:0] alu_flags;
  logic              unused_fields;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] nxt;
  logic [OP_W-1:0]    op_q;
  logic [OP_W-1:0]    op_nxt;
  logic               stat_en_q;
  logic               stat_en_nxt;
  logic               rf_we_q;
  logic               rf_we_nxt;
  logic               wb_sel_q;
  logic               wb_sel_nxt;
  logic               halted_q;
  logic               halted_nxt;

  assign instr         = instr_t'(bus.ir);
  assign unused_fields = ^{instr.rd, instr.rs};
  assign alu_b         = (instr.op == OP_ALU_IMM) ? ext_imm(instr.imm) : bus.rsb;

  sisc_alu_core u_alu (
    .a      (bus.rsa),
    .b      (alu_b),
    .mm     (instr.mm),
    .result (alu_res),
    .flags  (alu_flags)
  );

  // Opcode is captured in DECODE so later stages do not depend on re-decoding ir
  always_comb begin
    nxt         = state;
    op_nxt      = op_q;
    stat_en_nxt = 1'b0;
    rf_we_nxt   = 1'b0;
    wb_sel_nxt  = 1'b0;
    halted_nxt  = 1'b0;
    case (state)
      ST_RESET:     nxt = ST_FETCH;
      ST_FETCH:     nxt = ST_DECODE;
      ST_DECODE: begin
        op_nxt = instr.op;
        if (instr.op == OP_HLT) begin
          nxt        = ST_HALT;
          halted_nxt = 1'b1;
        end else begin
          nxt         = ST_EXECUTE;
          stat_en_nxt = is_alu_op(instr.op) && !instr.mm[MM_W-1];
          wb_sel_nxt  = (instr.op == OP_LOD);
        end
      end
      ST_EXECUTE: begin
        nxt        = ST_MEM;
        wb_sel_nxt = (op_q == OP_LOD);
      end
      ST_MEM: begin
        nxt        = ST_WRITEBACK;
        wb_sel_nxt = (op_q == OP_LOD);
        rf_we_nxt  = is_alu_op(op_q) || (op_q == OP_LOD);
      end
      ST_WRITEBACK: nxt = ST_FETCH;
      ST_HALT: begin
        nxt        = ST_HALT;
        halted_nxt = 1'b1;
      end
      default:      nxt = ST_RESET;
    endcase
  end

  // Enables are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state     <= ST_RESET;
      op_q      <= OP_NOP;
      stat_en_q <= 1'b0;
      rf_we_q   <= 1'b0;
      wb_sel_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state     <= nxt;
      op_q      <= op_nxt;
      stat_en_q <= stat_en_nxt;
      rf_we_q   <= rf_we_nxt;
      wb_sel_q  <= wb_sel_nxt;
      halted_q  <= halted_nxt;
    end
  end

  assign bus.alu_result = alu_res;
  assign bus.stat       = alu_flags;
  assign bus.stat_en    = stat_en_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.wb_sel     = wb_sel_q;
  assign bus.halted     = halted_q;
  assign bus.write_data = wb_sel_q ? bus.mem_data : alu_res;

endmodule

// File: tb/tb_sisc_exec_unit.sv
// Scoreboard bench for sisc_exec_unit: random instructions against an arithmetic reference model.
// Expectations track SISC_IMM_SIGNEXT_EN the same way the design does.
module tb_sisc_exec_unit;
  import sisc_pkg::*;

  typedef struct {
    int          cycle;
    logic [31:0] data;
    logic [3:0]  flags;
    logic        sel;
  } ev_t;

  logic clk = 1'b0;
  logic rst_f;
  int   cyc = 0;
  int   fetch_cyc = 0;
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  ev_t q_stat[$];
  ev_t q_wb[$];
  int  q_sel[$];

  sisc_exec_unit_if bus();

  sisc_exec_unit dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got pulse expected none (cycle %0d)", name, cyc);
  endtask

  // Reference behaviour from the instruction semantics using wide integer arithmetic
  function automatic void model(input logic [3:0] op, input logic [3:0] mm,
                                input logic [31:0] a, input logic [31:0] rsb,
                                input logic [15:0] imm,
                                output logic [31:0] res, output logic [3:0] fl);
    logic [31:0] b;
    longint sa, sb, sr;
    longint unsigned ua, ub;
    logic c, v;
`ifdef SISC_IMM_SIGNEXT_EN
    b = (op == 4'h2) ? {{16{imm[15]}}, imm} : rsb;
`else
    b = (op == 4'h2) ? {16'h0, imm} : rsb;
`endif
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    c = 1'b0; v = 1'b0;
    case (mm)
      4'd0: begin
        res = a + b; c = (ua + ub) > 64'hFFFF_FFFF;
        sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd1: begin
        res = a - b; c = a < b;
        sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: res = ~a;
      4'd3: res = a | b;
      4'd4: res = a & b;
      4'd5: res = a ^ b;
      4'd6: res = a << b[4:0];
      4'd7: res = a >> b[4:0];
      default: res = a;
    endcase
    fl = {c, v, res[31], res == 32'h0};
  endfunction

  // Drive one instruction at its FETCH cycle; 'full' false stops after EXECUTE
  task automatic issue(input logic [3:0] op, input logic [3:0] mm, input logic [31:0] a,
                       input logic [31:0] rb, input logic [15:0] imm, input logic [31:0] mem,
                       input bit full);
    logic [31:0] res;
    logic [3:0]  fl;
    logic [7:0]  regs;
    regs = 8'($urandom);
    bus.ir = {op, mm, regs, imm};
    bus.rsa = a; bus.rsb = rb; bus.mem_data = mem;
    if (op == 4'h1 || op == 4'h2) begin
      model(op, mm, a, rb, imm, res, fl);
      if (mm < 4'd8) q_stat.push_back('{fetch_cyc + 2, res, fl, 1'b0});
      if (full) q_wb.push_back('{fetch_cyc + 4, res, 4'h0, 1'b0});
    end else if (op == 4'h8) begin
      q_sel.push_back(fetch_cyc + 2);
      if (full) begin
        q_sel.push_back(fetch_cyc + 3);
        q_sel.push_back(fetch_cyc + 4);
        q_wb.push_back('{fetch_cyc + 4, mem, 4'h0, 1'b1});
      end
    end
    if (full) begin
      repeat (5) @(negedge clk);
      fetch_cyc += 5;
    end else begin
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic random_instr();
    int k;
    logic [3:0] op;
    k = $urandom_range(0, 9);
    if (k < 4)       op = 4'h1;
    else if (k < 7)  op = 4'h2;
    else if (k == 7) op = 4'h8;
    else if (k == 8) op = 4'h0;
    else             op = 4'($urandom_range(3, 7));
    issue(op, 4'($urandom_range(0, 15)), $urandom, $urandom, 16'($urandom), $urandom, 1'b1);
  endtask

  task automatic check_idle(input string tag, input logic exp_halted);
    check({tag, "_rf_we"}, 32'(bus.rf_we), 32'h0);
    check({tag, "_stat_en"}, 32'(bus.stat_en), 32'h0);
    check({tag, "_wb_sel"}, 32'(bus.wb_sel), 32'h0);
    check({tag, "_halted"}, 32'(bus.halted), 32'(exp_halted));
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.stat_en === 1'b1) begin
        if (q_stat.size() == 0) unexpected("stat_en");
        else begin
          ev_t e;
          e = q_stat.pop_front();
          check("stat_en_cycle", 32'(cyc), 32'(e.cycle));
          check("alu_result", bus.alu_result, e.data);
          check("stat", 32'(bus.stat), 32'(e.flags));
        end
      end
      if (bus.rf_we === 1'b1) begin
        if (q_wb.size() == 0) unexpected("rf_we");
        else begin
          ev_t e;
          e = q_wb.pop_front();
          check("rf_we_cycle", 32'(cyc), 32'(e.cycle));
          check("write_data", bus.write_data, e.data);
          check("wb_sel_at_wb", 32'(bus.wb_sel), 32'(e.sel));
        end
      end
      if (bus.wb_sel === 1'b1) begin
        if (q_sel.size() == 0) unexpected("wb_sel");
        else check("wb_sel_cycle", 32'(cyc), 32'(q_sel.pop_front()));
      end
    end
  end

  initial begin
    bus.ir = '0; bus.rsa = '0; bus.rsb = '0; bus.mem_data = '0;
    rst_f = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset", 1'b0);
    mon_en = 1'b1;
    rst_f = 1'b0;
    fetch_cyc = cyc + 1;
    @(negedge clk);

    issue(4'h1, 4'h0, 32'd5, 32'd3, 16'h0, 32'h0, 1'b1);
    issue(4'h1, 4'h1, 32'd3, 32'd5, 16'h0, 32'h0, 1'b1);
    issue(4'h1, 4'h0, 32'h7FFF_FFFF, 32'd1, 16'h0, 32'h0, 1'b1);
    issue(4'h2, 4'h0, 32'd1, 32'h1234_5678, 16'hFFFF, 32'h0, 1'b1);
    issue(4'h8, 4'h0, 32'h1, 32'h2, 16'h0, 32'hDEAD_BEEF, 1'b1);
    issue(4'h1, 4'h9, 32'hA5A5_0000, 32'h1, 16'h0, 32'h0, 1'b1);
    for (int i = 0; i < 40; i++) random_instr();

    issue(4'hF, 4'h0, $urandom, $urandom, 16'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_idle("halt", 1'b1);
      @(negedge clk);
    end

    rst_f = 1'b1;
    @(negedge clk);
    check_idle("halt_reset", 1'b0);
    rst_f = 1'b0;
    fetch_cyc = cyc + 1;
    @(negedge clk);

    issue(4'h1, 4'h0, 32'd10, 32'd20, 16'h0, 32'h0, 1'b0);
    rst_f = 1'b1;
    @(negedge clk);
    check_idle("exec_reset", 1'b0);
    rst_f = 1'b0;
    fetch_cyc = cyc + 1;
    @(negedge clk);

    issue(4'h8, 4'h0, 32'h0, 32'h0, 16'h0, 32'hCAFE_F00D, 1'b1);
    for (int i = 0; i < 6; i++) random_instr();

    repeat (3) @(negedge clk);
    check("pending_stat_events", 32'(q_stat.size()), 32'h0);
    check("pending_wb_events", 32'(q_wb.size()), 32'h0);
    check("pending_sel_events", 32'(q_sel.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
